inference_sequencer: RTL and testbench
======================================

Name: inference_sequencer

Overview:
- Top-level run controller for one CNN inference: conv layer, then pool layer, then dense layer, then an argmax over the dense output vector.
- Issues one-cycle start pulses to each layer and waits for that layer's done.
- Runs a per-stage watchdog.
- Reports the winning class index and score with a one-cycle done pulse.
- Sits between the host/UART control logic and the layer datapaths.

Parameters:
- DATA_WIDTH, 16, width of the signed dense output elements.
- OUT_DIM, 10, number of dense outputs (classes); must be >= 2.
- TIMEOUT_CYCLES, 1000000, maximum cycles spent in any one WAIT state before error.
- IDX_W, $clog2(OUT_DIM), class index width (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run request; honoured only in IDLE, DONE or ERROR.
- busy  out  1  high from the cycle after start is accepted until DONE/ERROR is entered.
- done  out  1  one-cycle pulse, run completed; class_idx/class_score valid.
- error  out  1  level; high while in ERROR.
- err_stage  out  2  0=none, 1=conv, 2=pool, 3=dense timeout.
- conv_start  out  1  one-cycle pulse to the conv layer.
- conv_done  in  1  conv completion.
- pool_start  out  1  one-cycle pulse to the pool layer.
- pool_done  in  1  pool completion.
- fc_start  out  1  one-cycle pulse to the dense layer.
- fc_done  in  1  dense completion.
- fc_out_vec  in  OUT_DIM x DATA_WIDTH  signed dense outputs; held stable by the dense layer after fc_done.
- class_idx  out  IDX_W  argmax result.
- class_score  out  DATA_WIDTH  signed maximum value.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0: busy, done, error, err_stage, all *_start, class_idx, class_score.
  - Watchdog and argmax counters 0.
- FSM states: IDLE, CONV_GO, CONV_WAIT, POOL_GO, POOL_WAIT, FC_GO, FC_WAIT, ARGMAX, DONE, ERROR.
- Start acceptance:
  - start=1 at an edge in IDLE, DONE or ERROR -> CONV_GO.
  - The same edge clears error and err_stage to 0.
  - start in any other state is ignored; there is no queueing.
- GO states:
  - X_GO lasts exactly one cycle with X_start=1, then goes to X_WAIT.
  - *_start is registered, decoded from the state.
- WAIT states:
  - Entering X_WAIT clears the watchdog.
  - X_done is sampled only in X_WAIT; done asserted in the GO cycle is ignored.
  - First edge in X_WAIT with X_done=1 -> next GO state (CONV->POOL_GO, POOL->FC_GO, FC->ARGMAX).
  - Level or pulse done are both accepted.
- Watchdog:
  - Increments each cycle in a WAIT state.
  - If it reaches TIMEOUT_CYCLES-1 without done -> ERROR, err_stage set to the stage code.
  - done and timeout on the same edge: done wins.
- ARGMAX:
  - Sequential scan over OUT_DIM elements.
  - Entry cycle loads best=fc_out_vec[0], best_idx=0, i=1.
  - Each following cycle compares fc_out_vec[i] with best as signed; strictly greater replaces best, so ties keep the lowest index.
  - After i=OUT_DIM-1 is compared -> DONE; class_idx/class_score are registered on that edge.
  - ARGMAX occupancy is OUT_DIM cycles.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - class_idx/class_score hold until the next ARGMAX completes.
  - start in the DONE cycle is accepted (back-to-back runs).
- ERROR:
  - error=1, busy=0; no *_start issued.
  - Held until start or reset. class outputs retain their prior values.
- busy is 1 in every state except IDLE, DONE and ERROR.
- Reset mid-run: immediate return to IDLE with all outputs 0. No pulse is emitted on reset release.
- Latency from the start edge to done, with zero-latency layers:
  - start edge -> CONV_GO; then 2 cycles per layer (GO + one WAIT cycle) x3 = 6.
  - ARGMAX adds OUT_DIM cycles, DONE adds 1.
  - done is high in cycle 7+OUT_DIM after the start edge.

Decomposition:
- Package cnn_seq_pkg:
  - seq_state_t enum.
  - err_stage_t codes (ERR_NONE, ERR_CONV, ERR_POOL, ERR_FC).
- Sub-module argmax_seq (DATA_WIDTH, OUT_DIM):
  - Inputs: go, vec.
  - Outputs: valid pulse, idx, score.
  - The sequencer FSM waits on valid in ARGMAX.

Test Plan:
- Nominal run, OUT_DIM=3, each done asserted 5 cycles after its start, fc_out_vec=[12,9,11] -> exactly one pulse each of conv_start, pool_start, fc_start, in order; done pulse; class_idx=0, class_score=12; busy low after done.
- Tie and negative values: fc_out_vec=[5,5,-3] -> idx 0, score 5. fc_out_vec=[-4,-2,-9] -> idx 1, score -2 (signed compare).
- Timeout, TIMEOUT_CYCLES=50, pool_done never asserted -> error=1, err_stage=2 at 50 cycles into POOL_WAIT; fc_start never pulses; a subsequent start clears error and the run completes normally.
- Start while busy: second start pulse during CONV_WAIT -> ignored; exactly one conv_start per run.
- Early done: conv_done held high across the CONV_GO cycle -> ignored in CONV_GO, accepted on the first CONV_WAIT edge; pool_start follows one cycle later.
- Reset mid-run: assert reset during FC_WAIT -> all outputs 0 asynchronously. After release, no spurious done/start; a new start runs to class_idx=0, score=12 with back-to-back start in the DONE cycle accepted.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// Shared types for the CNN inference sequencer: FSM state encoding and
// the error-stage codes reported on err_stage.
package cnn_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CONV_GO   = 4'd1,
    S_CONV_WAIT = 4'd2,
    S_POOL_GO   = 4'd3,
    S_POOL_WAIT = 4'd4,
    S_FC_GO     = 4'd5,
    S_FC_WAIT   = 4'd6,
    S_ARGMAX    = 4'd7,
    S_DONE      = 4'd8,
    S_ERROR     = 4'd9
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CONV = 2'd1,
    ERR_POOL = 2'd2,
    ERR_FC   = 2'd3
  } err_stage_t;

endpackage

// File: rtl/argmax_seq.sv
// Sequential argmax over the dense output vector. A go pulse loads
// element 0 as the running best; each following cycle compares one more
// element as signed. valid/idx/score are presented combinationally in the
// cycle that compares the last element so the caller can register them on
// that same edge.
module argmax_seq
  import cnn_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_DIM    = 10,
  localparam int IDX_W     = $clog2(OUT_DIM)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               go,
  input  logic [OUT_DIM-1:0][DATA_WIDTH-1:0] vec,
  output logic                               valid,
  output logic [IDX_W-1:0]                   idx,
  output logic [DATA_WIDTH-1:0]              score
);

  logic                         active_r;
  logic [IDX_W-1:0]             i_r;
  logic [IDX_W-1:0]             best_idx_r;
  logic signed [DATA_WIDTH-1:0] best_r;
  logic signed [DATA_WIDTH-1:0] cand_s;
  logic                         better_s;

  // Compare the current candidate with the running best; ties keep the lower index.
  always_comb begin
    cand_s   = vec[i_r];
    better_s = (cand_s > best_r);
    valid    = active_r && (i_r == IDX_W'(OUT_DIM - 1));
    if (better_s) begin
      idx   = i_r;
      score = cand_s;
    end else begin
      idx   = best_idx_r;
      score = best_r;
    end
  end

  // Scan state: load on go, then step one element per cycle until the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_r   <= 1'b0;
      i_r        <= '0;
      best_idx_r <= '0;
      best_r     <= '0;
    end else if (go) begin
      active_r   <= 1'b1;
      i_r        <= IDX_W'(1);
      best_idx_r <= '0;
      best_r     <= vec[0];
    end else if (active_r) begin
      best_idx_r <= idx;
      best_r     <= score;
      if (valid) begin
        active_r <= 1'b0;
        i_r      <= '0;
      end else begin
        i_r <= i_r + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// Run controller for one CNN inference: conv -> pool -> dense -> argmax.
// Each layer gets a one-cycle start pulse and is then waited on under a
// per-stage watchdog. All outputs are registered and updated on the same
// edge as the state transition that implies them.
module inference_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int OUT_DIM        = 10,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int IDX_W         = $clog2(OUT_DIM)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [1:0]                         err_stage,
  output logic                               conv_start,
  input  logic                               conv_done,
  output logic                               pool_start,
  input  logic                               pool_done,
  output logic                               fc_start,
  input  logic                               fc_done,
  input  logic [OUT_DIM-1:0][DATA_WIDTH-1:0] fc_out_vec,
  output logic [IDX_W-1:0]                   class_idx,
  output logic [DATA_WIDTH-1:0]              class_score
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_t              state_r;
  logic [WD_W-1:0]         wd_r;
  logic                    argmax_go_r;
  logic                    wd_expired;
  logic                    am_valid;
  logic [IDX_W-1:0]        am_idx;
  logic [DATA_WIDTH-1:0]   am_score;

  assign wd_expired = (wd_r == WD_LAST);

  argmax_seq #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_DIM   (OUT_DIM)
  ) u_argmax (
    .clk  (clk),
    .reset(reset),
    .go   (argmax_go_r),
    .vec  (fc_out_vec),
    .valid(am_valid),
    .idx  (am_idx),
    .score(am_score)
  );

  // Sequencer FSM with registered pulses, status flags, watchdog and results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      wd_r        <= '0;
      argmax_go_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_stage   <= ERR_NONE;
      conv_start  <= 1'b0;
      pool_start  <= 1'b0;
      fc_start    <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
    end else begin
      conv_start  <= 1'b0;
      pool_start  <= 1'b0;
      fc_start    <= 1'b0;
      done        <= 1'b0;
      argmax_go_r <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_r    <= S_CONV_GO;
            conv_start <= 1'b1;
            busy       <= 1'b1;
            error      <= 1'b0;
            err_stage  <= ERR_NONE;
          end else if (state_r == S_DONE) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        S_CONV_GO: begin
          state_r <= S_CONV_WAIT;
          wd_r    <= '0;
        end
        S_CONV_WAIT: begin
          if (conv_done) begin
            state_r    <= S_POOL_GO;
            pool_start <= 1'b1;
          end else if (wd_expired) begin
            state_r   <= S_ERROR;
            error     <= 1'b1;
            busy      <= 1'b0;
            err_stage <= ERR_CONV;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        S_POOL_GO: begin
          state_r <= S_POOL_WAIT;
          wd_r    <= '0;
        end
        S_POOL_WAIT: begin
          if (pool_done) begin
            state_r  <= S_FC_GO;
            fc_start <= 1'b1;
          end else if (wd_expired) begin
            state_r   <= S_ERROR;
            error     <= 1'b1;
            busy      <= 1'b0;
            err_stage <= ERR_POOL;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        S_FC_GO: begin
          state_r <= S_FC_WAIT;
          wd_r    <= '0;
        end
        S_FC_WAIT: begin
          if (fc_done) begin
            state_r     <= S_ARGMAX;
            argmax_go_r <= 1'b1;
          end else if (wd_expired) begin
            state_r   <= S_ERROR;
            error     <= 1'b1;
            busy      <= 1'b0;
            err_stage <= ERR_FC;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        S_ARGMAX: begin
          if (am_valid) begin
            state_r     <= S_DONE;
            done        <= 1'b1;
            busy        <= 1'b0;
            class_idx   <= am_idx;
            class_score <= am_score;
          end else begin
            state_r <= S_ARGMAX;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Self-checking bench for inference_sequencer (OUT_DIM=3, TIMEOUT_CYCLES=50).
// Layer responders are modelled in the bench; expected timing comes from the
// per-layer cost (GO cycle + done delay) and expected results from a
// max-then-first-occurrence argmax model.
module tb_inference_sequencer;

  localparam int DW = 16;
  localparam int OD = 3;
  localparam int TO = 50;
  localparam int IW = 2;

  typedef logic [OD-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t vec;
    int   dc;
    int   dp;
    int   df;
    int   exp_idx;
    int   exp_score;
  } case_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, error;
  logic [1:0]    err_stage;
  logic          conv_start, pool_start, fc_start;
  logic          conv_done, pool_done, fc_done;
  vec_t          fc_out_vec;
  logic [IW-1:0] class_idx;
  logic [DW-1:0] class_score;

  int total = 0;
  int bad   = 0;
  int last_idx   = 0;
  int last_score = 0;
  case_t tbl[7];

  always #5 clk = ~clk;

  inference_sequencer #(
    .DATA_WIDTH    (DW),
    .OUT_DIM       (OD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_stage  (err_stage),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .pool_start (pool_start),
    .pool_done  (pool_done),
    .fc_start   (fc_start),
    .fc_done    (fc_done),
    .fc_out_vec (fc_out_vec),
    .class_idx  (class_idx),
    .class_score(class_score)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mkvec(input int a, input int b, input int c);
    vec_t v;
    v[0] = DW'(a);
    v[1] = DW'(b);
    v[2] = DW'(c);
    return v;
  endfunction

  // Reference: find the maximum signed value, then the first index holding it.
  function automatic void ref_argmax(input vec_t v, output int idx, output int sc);
    int vals[OD];
    int mx;
    for (int k = 0; k < OD; k++) vals[k] = $signed(v[k]);
    mx = vals[0];
    for (int k = 1; k < OD; k++) if (vals[k] > mx) mx = vals[k];
    idx = -1;
    for (int k = 0; k < OD; k++) if (idx < 0 && vals[k] == mx) idx = k;
    sc = mx;
  endfunction

  // One complete run with layer delays dc/dp/df (cycles from start pulse to done pulse).
  task automatic run(input string nm, input vec_t v, input int dc, input int dp, input int df,
                     input int exp_idx, input int exp_score, input bit do_start, input bit b2b,
                     input bit early, input int ghost);
    int n, c_cnt, p_cnt, f_cnt, c_at, p_at, f_at, c_due, p_due, f_due, done_at, err1;
    bit busy_ok;
    n = 0; c_cnt = 0; p_cnt = 0; f_cnt = 0;
    c_at = -1; p_at = -1; f_at = -1; c_due = -1; p_due = -1; f_due = -1;
    done_at = -1; err1 = -1; busy_ok = 1'b1;
    fc_out_vec = v;
    if (do_start) start = 1'b1;
    if (early) conv_done = 1'b1;
    while (done_at < 0 && n < 300) begin
      n++;
      @(negedge clk);
      start = 1'b0;
      if (conv_start) begin c_cnt++; c_at = n; c_due = n + dc; end
      if (pool_start) begin p_cnt++; p_at = n; p_due = n + dp; end
      if (fc_start)   begin f_cnt++; f_at = n; f_due = n + df; end
      if (n == 1) err1 = int'(error) + int'(err_stage);
      if (done) done_at = n;
      else if (!busy) busy_ok = 1'b0;
      conv_done = early ? (p_cnt == 0) : (n == c_due);
      pool_done = (n == p_due);
      fc_done   = (n == f_due);
      if (n == ghost) start = 1'b1;
    end
    conv_done = 1'b0; pool_done = 1'b0; fc_done = 1'b0;
    chk({nm, "/done_cycle"}, done_at, 4 + dc + dp + df + OD);
    chk({nm, "/conv_pulses"}, c_cnt, 1);
    chk({nm, "/pool_pulses"}, p_cnt, 1);
    chk({nm, "/fc_pulses"}, f_cnt, 1);
    chk({nm, "/conv_at"}, c_at, 1);
    chk({nm, "/pool_at"}, p_at, 2 + dc);
    chk({nm, "/fc_at"}, f_at, 3 + dc + dp);
    chk({nm, "/err_cleared"}, err1, 0);
    chk({nm, "/busy_in_run"}, int'(busy_ok), 1);
    chk({nm, "/class_idx"}, int'(class_idx), exp_idx);
    chk({nm, "/class_score"}, int'($signed(class_score)), exp_score);
    chk({nm, "/busy_at_done"}, int'(busy), 0);
    chk({nm, "/error_at_done"}, int'(error), 0);
    last_idx = exp_idx;
    last_score = exp_score;
    if (b2b) begin
      start = 1'b1;
    end else begin
      @(negedge clk);
      chk({nm, "/done_one_cycle"}, int'(done), 0);
      chk({nm, "/busy_after"}, int'(busy), 0);
    end
  endtask

  // Run where one layer never answers; checks the watchdog fires at the right cycle.
  task automatic timeout_run(input string nm, input bit conv_hang, input int exp_stage);
    int n, c_due, p_at, err_at, f_cnt, drop, extra;
    n = 0; c_due = -1; p_at = -1; err_at = -1; f_cnt = 0; drop = 0; extra = 0;
    fc_out_vec = mkvec(1, 2, 3);
    start = 1'b1;
    while (err_at < 0 && n < 200) begin
      n++;
      @(negedge clk);
      start = 1'b0;
      if (conv_start && !conv_hang) c_due = n + 2;
      if (pool_start) p_at = n;
      if (fc_start) f_cnt++;
      if (error) err_at = n;
      conv_done = (n == c_due);
    end
    conv_done = 1'b0;
    chk({nm, "/err_cycle"}, err_at, conv_hang ? (TO + 2) : (p_at + TO + 1));
    chk({nm, "/err_stage"}, int'(err_stage), exp_stage);
    chk({nm, "/busy_in_err"}, int'(busy), 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!error) drop++;
      if (fc_start || conv_start || pool_start || done) extra++;
    end
    chk({nm, "/error_held"}, drop, 0);
    chk({nm, "/no_pulses"}, extra + f_cnt, 0);
    chk({nm, "/idx_kept"}, int'(class_idx), last_idx);
    chk({nm, "/score_kept"}, int'($signed(class_score)), last_score);
  endtask

  initial begin
    int c_due, p_due, f_at, n, spur;
    bit hit;
    reset = 1'b0; start = 1'b0;
    conv_done = 1'b0; pool_done = 1'b0; fc_done = 1'b0;
    fc_out_vec = '0;

    tbl[0] = '{mkvec(12, 9, 11), 5, 5, 5, 0, 12};
    tbl[1] = '{mkvec(5, 5, -3), 1, 1, 1, 0, 5};
    tbl[2] = '{mkvec(-4, -2, -9), 1, 2, 3, 1, -2};
    tbl[3] = '{mkvec(1, 2, 3), 2, 1, 1, 2, 3};
    tbl[4] = '{mkvec(-32768, -32767, -32768), 1, 1, 2, 1, -32767};
    tbl[5] = '{mkvec(0, 32767, 32767), 3, 1, 1, 1, 32767};
    tbl[6] = '{mkvec(7, 7, 8), 1, 3, 1, 2, 8};

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst/busy", int'(busy), 0);
    chk("rst/done", int'(done), 0);
    chk("rst/error", int'(error), 0);
    chk("rst/err_stage", int'(err_stage), 0);
    chk("rst/starts", int'(conv_start) + int'(pool_start) + int'(fc_start), 0);
    chk("rst/class", int'(class_idx) + int'(class_score), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 7; t++)
      run($sformatf("tbl%0d", t), tbl[t].vec, tbl[t].dc, tbl[t].dp, tbl[t].df,
          tbl[t].exp_idx, tbl[t].exp_score, 1'b1, 1'b0, 1'b0, 0);

    // second start during CONV_WAIT is ignored
    run("ghost", tbl[0].vec, 5, 5, 5, 0, 12, 1'b1, 1'b0, 1'b0, 3);
    // conv_done held high across CONV_GO
    run("early", tbl[0].vec, 1, 2, 2, 0, 12, 1'b1, 1'b0, 1'b1, 0);

    timeout_run("to_conv", 1'b1, 1);
    timeout_run("to_pool", 1'b0, 2);
    run("recover", tbl[2].vec, 2, 2, 2, 1, -2, 1'b1, 1'b0, 1'b0, 0);

    // randomized runs against the reference model
    for (int r = 0; r < 24; r++) begin
      vec_t v;
      int ei, es, dc, dp, df;
      logic [31:0] tmp;
      for (int k = 0; k < OD; k++) begin
        tmp = $urandom();
        v[k] = (r % 2 == 0) ? tmp[DW-1:0] : DW'(int'($urandom_range(0, 6)) - 3);
      end
      dc = int'($urandom_range(1, 4));
      dp = int'($urandom_range(1, 4));
      df = int'($urandom_range(1, 4));
      ref_argmax(v, ei, es);
      run($sformatf("rnd%0d", r), v, dc, dp, df, ei, es, 1'b1, 1'b0, 1'b0,
          (r % 3 == 0) ? 2 : 0);
    end

    // reset during FC_WAIT
    fc_out_vec = mkvec(12, 9, 11);
    start = 1'b1; c_due = -1; p_due = -1; f_at = -1; n = 0; hit = 1'b0;
    while (!hit && n < 60) begin
      n++;
      @(negedge clk);
      start = 1'b0;
      if (conv_start) c_due = n + 2;
      if (pool_start) p_due = n + 2;
      if (fc_start) f_at = n;
      conv_done = (n == c_due);
      pool_done = (n == p_due);
      if (f_at > 0 && n == f_at + 3) hit = 1'b1;
    end
    conv_done = 1'b0; pool_done = 1'b0;
    chk("midrst/reached_fc_wait", int'(hit) + int'(busy), 2);
    reset = 1'b0;
    #1;
    chk("midrst/busy", int'(busy), 0);
    chk("midrst/error", int'(error) + int'(err_stage), 0);
    chk("midrst/done_starts", int'(done) + int'(conv_start) + int'(pool_start) + int'(fc_start), 0);
    chk("midrst/class_idx", int'(class_idx), 0);
    chk("midrst/class_score", int'(class_score), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    spur = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      spur += int'(done) + int'(conv_start) + int'(pool_start) + int'(fc_start) + int'(busy);
    end
    chk("midrst/no_spurious", spur, 0);
    run("b2b_a", mkvec(12, 9, 11), 1, 1, 1, 0, 12, 1'b1, 1'b1, 1'b0, 0);
    run("b2b_b", mkvec(-4, -2, -9), 1, 1, 1, 1, -2, 1'b0, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
